// File: rtl/ring_buff_sched.sv
// ring_buff_sched
//   Controller for one shared ring buffer. Round-robin arbitration of NUM_REQ
//   producers onto the buffer's single write port, read-enable sequencing
//   towards one consumer, and high/low watermark throttling with hysteresis.
//   A flush blocks writes until the buffer reports empty.
//
// Ports
//   clock, reset    clock and asynchronous active-high reset
//   I_Req/I_Data    per-producer request and data (slice i = [i*WIDTH_DATA +: WIDTH_DATA])
//   O_Gnt           one-hot grant; the token is accepted in the same cycle
//   O_We/O_WData    buffer write port
//   I_Full/I_Empty  buffer status flags
//   I_Num           buffer occupancy (registered in the buffer)
//   I_Rdy           consumer ready
//   O_Re/O_Vld      buffer read-enable / consumer valid (identical)
//   I_Flush         flush request pulse
//   O_FlushDone     one-cycle pulse when the flush completes
//   O_Throttle      high while writes are blocked by the watermark
module ring_buff_sched #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH_BUFF = 16,
    parameter int HI_MARK    = 12,
    parameter int LO_MARK    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            I_Req,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] I_Data,
    output logic [NUM_REQ-1:0]            O_Gnt,
    output logic                          O_We,
    output logic [WIDTH_DATA-1:0]         O_WData,
    input  logic                          I_Full,
    input  logic                          I_Empty,
    input  logic [$clog2(DEPTH_BUFF):0]   I_Num,
    input  logic                          I_Rdy,
    output logic                          O_Re,
    output logic                          O_Vld,
    input  logic                          I_Flush,
    output logic                          O_FlushDone,
    output logic                          O_Throttle
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NUM_W = $clog2(DEPTH_BUFF) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_THROTTLE,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               throttle_q, throttle_d;
    logic               flush_done_q, flush_done_d;

    logic               write_ok;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   scan_idx;
    logic               any_req;
    logic               at_hi;
    logic               below_lo;

    assign any_req  = |I_Req;
    assign at_hi    = (I_Num >= NUM_W'(HI_MARK));
    assign below_lo = (I_Num <  NUM_W'(LO_MARK));

    // Combinational outputs are forced low while reset is held, so a reset
    // in the middle of a burst removes grants and read-enables immediately.
    assign write_ok = ((state_q == S_IDLE) || (state_q == S_RUN)) && !I_Full && !reset;

    // Round-robin scan starting at rr_ptr_q; the first requester found wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path through the block leaves it unassigned (no latch).
        found    = 1'b0;
        win      = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && I_Req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    // Write port: one-hot grant and the matching data slice, zero otherwise.
    always_comb begin
        O_Gnt   = '0;
        O_We    = 1'b0;
        O_WData = '0;
        if (found && write_ok) begin
            O_Gnt[win] = 1'b1;
            O_We       = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (O_Gnt[i]) begin
                O_WData = I_Data[i*WIDTH_DATA +: WIDTH_DATA];
            end
        end
    end

    // Pointer advances past the winner only on a granted cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (O_We) begin
            rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    // Read side runs in every state; the buffer answers in the same cycle.
    assign O_Re  = I_Rdy && !I_Empty && !reset;
    assign O_Vld = O_Re;

    // Next-state logic. Flush overrides every other transition; while in
    // FLUSH the watermark is ignored until the buffer drains to empty.
    always_comb begin
        state_d = state_q;
        if (I_Flush) begin
            state_d = S_FLUSH;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req || !I_Empty) state_d = S_RUN;
                end
                S_RUN: begin
                    if (at_hi || I_Full)            state_d = S_THROTTLE;
                    else if (!any_req && I_Empty)   state_d = S_IDLE;
                end
                S_THROTTLE: begin
                    if (below_lo) state_d = S_RUN;
                end
                S_FLUSH: begin
                    if (I_Empty) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        throttle_d   = (state_d == S_THROTTLE);
        flush_done_d = (state_q == S_FLUSH) && (state_d != S_FLUSH);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            throttle_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            throttle_q   <= throttle_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign O_Throttle  = throttle_q;
    assign O_FlushDone = flush_done_q;

endmodule
